fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch front end of the pipeline: owns the program counter, produces the sequential next-PC (`outAddPc`) that feeds the `muxPc` next-PC select, and consumes that mux's result (`inMuxPc`) to advance. It registers the fetched instruction into the IF/ID pipeline register. It honours the hazard unit's stall and the branch unit's flush, where flush is the same taken-branch signal (`outAnd`) that drives the mux select. It also keeps a saturating stall-cycle counter for debug.

## Interface
- `tam`, 8, instruction word width in bits.
- `pcw`, 4, PC width in bits. Must match the `muxPc` data width.
- `clk` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `inMuxPc` in pcw: next PC from `muxPc`'s `outMuxPc`.
- `stall` in 1: hazard unit request to hold the PC and IF/ID.
- `flush` in 1: taken branch, tied to `outAnd`. Inserts a bubble into IF/ID.
- `instrIn` in tam: instruction memory read data. Combinational from `pcOut`.
- `pcOut` out pcw: current PC, driven to instruction memory.
- `outAddPc` out pcw: `pcOut`+1 mod 2^pcw. Combinational. Drives `muxPc`'s `inMuxAddPc`.
- `ifIdInstr` out tam: registered instruction.
- `ifIdPc` out pcw: registered PC+1 of that instruction, used for branch-target add.
- `ifIdValid` out 1: the IF/ID contents are a real instruction.
- `stallCnt` out 8: saturating count of stalled cycles since reset.

## Operation
- Reset (rstN=0, asynchronous) forces the following. Counter: `pcOut`=0. IF/ID: `ifIdInstr`=0, `ifIdPc`=0, `ifIdValid`=0. Debug: `stallCnt`=0. State: BOOT. `outAddPc` is therefore 1.
- States: BOOT, RUN, HOLD.
- BOOT
  - The first rising edge after rstN deasserts updates nothing except state, and moves to RUN.
  - This gives a one-cycle instruction memory settle after reset.
  - `stall` and `flush` are ignored in BOOT.
- RUN and HOLD apply the same rules at each edge, in this priority order:
  1. `flush`=1: `pcOut`<=`inMuxPc`, `ifIdInstr`<=0 (NOP), `ifIdPc`<=0, `ifIdValid`<=0, next state RUN. Flush wins over stall.
  2. `stall`=1: PC and IF/ID hold. `stallCnt` increments, saturating at 255. Next state HOLD.
  3. Otherwise: `pcOut`<=`inMuxPc`, `ifIdInstr`<=`instrIn`, `ifIdPc`<=`outAddPc`, `ifIdValid`<=1, next state RUN.
- Leaving HOLD (stall=0, flush=0) performs the rule 3 load on that same edge; there is no extra bubble.
- Width and wrap: all PC arithmetic is modulo 2^pcw, so `pcOut`=15 gives `outAddPc`=0. No overflow flag.
- The block never computes the jump target itself. The target arrives only through `inMuxPc`.

## Timing
- Latency is one cycle. At edge N, `instrIn` at `pcOut` is sampled into IF/ID. It is visible on `ifIdInstr` after edge N.
- `outAddPc` is combinational from `pcOut` and settles within the same cycle. With `flush`=0, the path `pcOut`→`outAddPc`→`muxPc`→`inMuxPc` must close in one cycle.
- `flush` and `stall` are sampled at the rising edge only. Both are level-sensitive, one decision per cycle.
- Throughput is one instruction per cycle when there is no stall or flush.
- Reset mid-operation takes effect immediately, without waiting for a clock, and returns the block to BOOT.

## Structure
- Shared pipeline package holds:
  - `PCW`=4 and `INSTR_W`=8 defaults;
  - the NOP encoding (all zeros);
  - the state encoding localparams BOOT=0, RUN=1, HOLD=2.
- Natural sub-module: `pc_incr`, the combinational pcw-bit +1 with wrap, reused by any later PC-relative logic.
- Rest of the block: one FSM `always`, one register `always` with asynchronous reset, and the saturating counter.

## Test plan
- Reset, then release. Cycle 1 is BOOT: `pcOut`=0, `outAddPc`=1, `ifIdValid`=0. At the next edge the state is RUN and `ifIdValid` is still 0.
- Sequential run with `inMuxPc` looped from `outAddPc`, `instrIn`=8'hA0+pc, for 17 cycles. Expected: `pcOut` sequence 0..15,0; `ifIdInstr`=A0..AF then A0; `ifIdPc` wraps 15→0 correctly.
- Stall held 3 cycles at `pcOut`=5. Expected: PC and IF/ID frozen, `stallCnt`=3. On release the next edge loads instr 5 and `pcOut`=6.
- Flush with `inMuxPc`=9 at `pcOut`=3. Expected after the edge: `pcOut`=9, `ifIdValid`=0, `ifIdInstr`=0. The following edge loads instr 9 with `ifIdPc`=10.
- Simultaneous `flush`=1 and `stall`=1, with `inMuxPc`=12. Expected: flush wins, `pcOut`=12, bubble inserted, `stallCnt` unchanged.
- Run 300 stall cycles, then assert rstN=0 mid-cycle. Expected: `stallCnt` saturates at 255; all outputs clear to 0 asynchronously and the state returns to BOOT.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared pipeline definitions for the fetch front end: default widths,
// the NOP encoding, the fetch FSM states and a saturating increment helper.
package fetch_pc_unit_pkg;

  localparam int PCW     = 4;
  localparam int INSTR_W = 8;
  localparam int CNT_W   = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_incr.sv
// Combinational PC + 1 with natural wrap at 2^W; reusable by any
// PC-relative logic.
module fetch_pc_unit_pc_incr #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = a + W'(1);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, sequential next-PC,
// IF/ID pipeline register with stall/flush handling and a stall counter.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int tam = INSTR_W,
  parameter int pcw = PCW
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic [pcw-1:0] inMuxPc,
  input  logic           stall,
  input  logic           flush,
  input  logic [tam-1:0] instrIn,
  output logic [pcw-1:0] pcOut,
  output logic [pcw-1:0] outAddPc,
  output logic [tam-1:0] ifIdInstr,
  output logic [pcw-1:0] ifIdPc,
  output logic           ifIdValid,
  output logic [7:0]     stallCnt
);

  state_t state;
  logic   active;
  logic   do_flush;
  logic   do_stall;
  logic   do_load;

  fetch_pc_unit_pc_incr #(.W(pcw)) u_pc_incr (
    .a (pcOut),
    .y (outAddPc)
  );

  // BOOT gives instruction memory a settle cycle, so stall/flush are ignored there.
  assign active   = (state != BOOT);
  assign do_flush = active && flush;
  assign do_stall = active && !flush && stall;
  assign do_load  = active && !flush && !stall;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        default: begin
          if (flush)      state <= RUN;
          else if (stall) state <= HOLD;
          else            state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcOut     <= '0;
      ifIdInstr <= '0;
      ifIdPc    <= '0;
      ifIdValid <= 1'b0;
    end else if (do_flush) begin
      pcOut     <= inMuxPc;
      ifIdInstr <= tam'(NOP_INSTR);
      ifIdPc    <= '0;
      ifIdValid <= 1'b0;
    end else if (do_load) begin
      pcOut     <= inMuxPc;
      ifIdInstr <= instrIn;
      ifIdPc    <= outAddPc;
      ifIdValid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stallCnt <= '0;
    end else if (do_stall) begin
      stallCnt <= sat_inc(stallCnt);
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: rule-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_fetch_pc_unit;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] inMuxPc;
  logic       stall;
  logic       flush;
  logic [7:0] instrIn;
  logic [3:0] pcOut;
  logic [3:0] outAddPc;
  logic [7:0] ifIdInstr;
  logic [3:0] ifIdPc;
  logic       ifIdValid;
  logic [7:0] stallCnt;

  logic       loop_mode;
  logic [3:0] mux_forced;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int m_pc    = 0;
  int m_instr = 0;
  int m_ifpc  = 0;
  int m_valid = 0;
  int m_cnt   = 0;
  int m_boot  = 1;

  fetch_pc_unit dut (
    .clk       (clk),
    .rstN      (rstN),
    .inMuxPc   (inMuxPc),
    .stall     (stall),
    .flush     (flush),
    .instrIn   (instrIn),
    .pcOut     (pcOut),
    .outAddPc  (outAddPc),
    .ifIdInstr (ifIdInstr),
    .ifIdPc    (ifIdPc),
    .ifIdValid (ifIdValid),
    .stallCnt  (stallCnt)
  );

  always #5 clk = ~clk;

  // Stimulus environment: mux either loops the sequential PC or forces a target,
  // instruction memory returns 0xA0 + address.
  assign inMuxPc = loop_mode ? outAddPc : mux_forced;
  assign instrIn = 8'hA0 + {4'h0, pcOut};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_pc <= 0; m_instr <= 0; m_ifpc <= 0; m_valid <= 0; m_cnt <= 0; m_boot <= 1;
    end else if (m_boot != 0) begin
      m_boot <= 0;
    end else if (flush) begin
      m_pc    <= loop_mode ? (m_pc + 1) % 16 : int'(mux_forced);
      m_instr <= 0;
      m_ifpc  <= 0;
      m_valid <= 0;
    end else if (stall) begin
      m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
    end else begin
      m_pc    <= loop_mode ? (m_pc + 1) % 16 : int'(mux_forced);
      m_instr <= 8'hA0 + m_pc;
      m_ifpc  <= (m_pc + 1) % 16;
      m_valid <= 1;
    end
  end

  always @(negedge clk) begin
    check("model_pcOut", 32'(pcOut), 32'(m_pc));
    check("model_outAddPc", 32'(outAddPc), 32'((m_pc + 1) % 16));
    check("model_ifIdInstr", 32'(ifIdInstr), 32'(m_instr));
    check("model_ifIdPc", 32'(ifIdPc), 32'(m_ifpc));
    check("model_ifIdValid", 32'(ifIdValid), 32'(m_valid));
    check("model_stallCnt", 32'(stallCnt), 32'(m_cnt));
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; flush = 1'b0; loop_mode = 1'b1; mux_forced = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("boot_pcOut", 32'(pcOut), 32'd0);
    check("boot_outAddPc", 32'(outAddPc), 32'd1);
    check("boot_valid", 32'(ifIdValid), 32'd0);
    step(1);
    check("boot_edge_pc", 32'(pcOut), 32'd0);
    check("boot_edge_valid", 32'(ifIdValid), 32'd0);

    for (int i = 0; i < 17; i++) begin
      step(1);
      check("seq_pc", 32'(pcOut), 32'((i + 1) % 16));
      check("seq_instr", 32'(ifIdInstr), 32'(8'hA0 + (i % 16)));
      check("seq_ifpc", 32'(ifIdPc), 32'((i + 1) % 16));
      check("seq_valid", 32'(ifIdValid), 32'd1);
    end
    step(4);
    check("pre_stall_pc", 32'(pcOut), 32'd5);

    stall = 1'b1;
    step(3);
    stall = 1'b0;
    check("stall_pc", 32'(pcOut), 32'd5);
    check("stall_instr", 32'(ifIdInstr), 32'hA4);
    check("stall_ifpc", 32'(ifIdPc), 32'd5);
    check("stall_cnt", 32'(stallCnt), 32'd3);
    step(1);
    check("release_instr", 32'(ifIdInstr), 32'hA5);
    check("release_pc", 32'(pcOut), 32'd6);

    step(13);
    check("pre_flush_pc", 32'(pcOut), 32'd3);
    loop_mode = 1'b0; mux_forced = 4'd9; flush = 1'b1;
    step(1);
    flush = 1'b0; loop_mode = 1'b1;
    check("flush_pc", 32'(pcOut), 32'd9);
    check("flush_valid", 32'(ifIdValid), 32'd0);
    check("flush_instr", 32'(ifIdInstr), 32'd0);
    step(1);
    check("post_flush_instr", 32'(ifIdInstr), 32'hA9);
    check("post_flush_ifpc", 32'(ifIdPc), 32'd10);

    loop_mode = 1'b0; mux_forced = 4'd12; flush = 1'b1; stall = 1'b1;
    step(1);
    flush = 1'b0; stall = 1'b0; loop_mode = 1'b1;
    check("both_pc", 32'(pcOut), 32'd12);
    check("both_valid", 32'(ifIdValid), 32'd0);
    check("both_cnt", 32'(stallCnt), 32'd3);
    step(1);
    check("after_both_pc", 32'(pcOut), 32'd13);

    stall = 1'b1;
    step(300);
    check("sat_cnt", 32'(stallCnt), 32'd255);
    check("sat_pc", 32'(pcOut), 32'd13);
    #2;
    rstN = 1'b0;
    #1;
    check("arst_pc", 32'(pcOut), 32'd0);
    check("arst_outAddPc", 32'(outAddPc), 32'd1);
    check("arst_instr", 32'(ifIdInstr), 32'd0);
    check("arst_ifpc", 32'(ifIdPc), 32'd0);
    check("arst_valid", 32'(ifIdValid), 32'd0);
    check("arst_cnt", 32'(stallCnt), 32'd0);

    // Back in BOOT: stall and flush on the first edge must be ignored.
    @(negedge clk);
    rstN = 1'b1; stall = 1'b1; flush = 1'b1; loop_mode = 1'b0; mux_forced = 4'd7;
    step(1);
    check("reboot_pc", 32'(pcOut), 32'd0);
    check("reboot_cnt", 32'(stallCnt), 32'd0);
    check("reboot_valid", 32'(ifIdValid), 32'd0);
    stall = 1'b0; flush = 1'b0; loop_mode = 1'b1;
    step(2);
    check("rerun_pc", 32'(pcOut), 32'd2);
    check("rerun_instr", 32'(ifIdInstr), 32'hA1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
